operand_fetch: RTL and testbench

Operand-fetch stage directly upstream of the 16-bit ALU. Accepts one 16-bit instruction per cycle over a valid/ready handshake, decodes the opcode into the ALU's 4-bit Control code, and reads two source operands from an internal 16 x 16-bit register file. The operands, Control and destination are presented to the ALU from a registered issue stage. A writeback port and a pending-write scoreboard stall read-after-write and write-after-write hazards.

---
 rtl/operand_fetch_if.sv | 28 ++
 rtl/operand_fetch.sv | 110 +++++++++++
 tb/tb_operand_fetch.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/operand_fetch_if.sv
// Handshake, writeback and ALU-issue signals between the fetch/decode front end,
// the operand_fetch stage and the downstream 16-bit ALU.
interface operand_fetch_if #(
  parameter int WIDTH = 16
);
  logic             InstrValid;
  logic [15:0]      Instr;
  logic             InstrReady;
  logic             WbEnable;
  logic [3:0]       WbReg;
  logic [WIDTH-1:0] WbData;
  logic [WIDTH-1:0] ReadData1;
  logic [WIDTH-1:0] ReadData2;
  logic [3:0]       Control;
  logic [3:0]       DestReg;
  logic             IssueValid;
  logic             IllegalOp;

  modport master (
    output InstrValid, Instr, WbEnable, WbReg, WbData,
    input  InstrReady, ReadData1, ReadData2, Control, DestReg, IssueValid, IllegalOp
  );

  modport slave (
    input  InstrValid, Instr, WbEnable, WbReg, WbData,
    output InstrReady, ReadData1, ReadData2, Control, DestReg, IssueValid, IllegalOp
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand-fetch stage: decodes opcode to ALU control, reads rs/rt with writeback
// bypass, and stalls RAW/WAW hazards via a per-register pending scoreboard.
module operand_fetch #(
  parameter int NUM_REGS = 16,
  parameter int WIDTH    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  operand_fetch_if.slave   bus
);

  function automatic logic [4:0] decode_op(input logic [3:0] op);
    case (op)
      4'h0:    return {1'b1, 4'b0000};
      4'h1:    return {1'b1, 4'b0001};
      4'h2:    return {1'b1, 4'b0010};
      4'h3:    return {1'b1, 4'b0110};
      4'h4:    return {1'b1, 4'b0111};
      4'h5:    return {1'b1, 4'b1100};
      default: return 5'b0_0000;
    endcase
  endfunction

  logic [WIDTH-1:0]    regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending;

  logic [3:0]          opcode, dst, rs, rt;
  logic                legal;
  logic [3:0]          ctrl_p0;
  logic                wb_write;
  logic [NUM_REGS-1:0] clr_mask, set_mask, eff_pending;
  logic                hazard, accept, issue, illegal_acc;
  logic [WIDTH-1:0]    rs_data_p0, rt_data_p0;

  logic [WIDTH-1:0]    rs_data_p1, rt_data_p1;
  logic [3:0]          ctrl_p1, dst_p1;
  logic                vld_p1, ill_p1;

  assign opcode = bus.Instr[15:12];
  assign dst    = bus.Instr[11:8];
  assign rs     = bus.Instr[7:4];
  assign rt     = bus.Instr[3:0];

  assign {legal, ctrl_p0} = decode_op(opcode);
  assign wb_write         = bus.WbEnable && (bus.WbReg != 4'd0);

  always_comb begin
    clr_mask    = '0;
    set_mask    = '0;
    rs_data_p0  = '0;
    rt_data_p0  = '0;
    if (wb_write) clr_mask = NUM_REGS'(1) << bus.WbReg;
    // A register being written back this cycle no longer counts as pending.
    eff_pending = pending & ~clr_mask;
    hazard      = legal && (((rs != 4'd0) && eff_pending[rs]) ||
                            ((rt != 4'd0) && eff_pending[rt]) ||
                            ((dst != 4'd0) && eff_pending[dst]));
    accept      = bus.InstrValid && rst_n && !hazard;
    issue       = accept && legal;
    illegal_acc = accept && !legal;
    if (issue && (dst != 4'd0)) set_mask = NUM_REGS'(1) << dst;
    if (rs != 4'd0) rs_data_p0 = (wb_write && bus.WbReg == rs) ? bus.WbData : regs[rs];
    if (rt != 4'd0) rt_data_p0 = (wb_write && bus.WbReg == rt) ? bus.WbData : regs[rt];
  end

  assign bus.InstrReady = rst_n && !hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_write) begin
      regs[bus.WbReg] <= bus.WbData;
    end
  end

  // Set is applied after clear so a same-cycle set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending & ~clr_mask) | set_mask;
  end

  // ---- p0 -> p1: issue register toward the ALU ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_data_p1 <= '0;
      rt_data_p1 <= '0;
      ctrl_p1    <= '0;
      dst_p1     <= '0;
      vld_p1     <= 1'b0;
      ill_p1     <= 1'b0;
    end else begin
      vld_p1 <= issue;
      ill_p1 <= illegal_acc;
      if (issue) begin
        rs_data_p1 <= rs_data_p0;
        rt_data_p1 <= rt_data_p0;
        ctrl_p1    <= ctrl_p0;
        dst_p1     <= dst;
      end
    end
  end

  assign bus.ReadData1  = rs_data_p1;
  assign bus.ReadData2  = rt_data_p1;
  assign bus.Control    = ctrl_p1;
  assign bus.DestReg    = dst_p1;
  assign bus.IssueValid = vld_p1;
  assign bus.IllegalOp  = ill_p1;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: reset, writeback/read, RAW stall with bypass,
// r0 and illegal handling, decode sweep, WAW stall and reset mid-stall.
module tb_operand_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  operand_fetch_if #(.WIDTH(16)) bus ();

  operand_fetch #(.NUM_REGS(16), .WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_issue(input string tag, input logic [15:0] r1, input logic [15:0] r2,
                           input logic [3:0] ctrl, input logic [3:0] dst);
    chk({tag, "_vld"},  {15'd0, bus.IssueValid}, 16'd1);
    chk({tag, "_rd1"},  bus.ReadData1, r1);
    chk({tag, "_rd2"},  bus.ReadData2, r2);
    chk({tag, "_ctl"},  {12'd0, bus.Control}, {12'd0, ctrl});
    chk({tag, "_dst"},  {12'd0, bus.DestReg}, {12'd0, dst});
  endtask

  initial begin
    bus.InstrValid = 1'b1;
    bus.Instr      = 16'h2100;
    bus.WbEnable   = 1'b0;
    bus.WbReg      = 4'd0;
    bus.WbData     = 16'h0000;

    // Reset held with a valid instruction present
    tick(); tick();
    chk("rst_ready", {15'd0, bus.InstrReady}, 16'd0);
    chk("rst_vld",   {15'd0, bus.IssueValid}, 16'd0);
    chk("rst_ill",   {15'd0, bus.IllegalOp},  16'd0);
    chk("rst_rd1",   bus.ReadData1, 16'h0000);
    chk("rst_ctl",   {12'd0, bus.Control}, 16'd0);

    // Release and issue ADD r1,r0,r0
    rst_n = 1'b1;
    #1;
    chk("add_ready", {15'd0, bus.InstrReady}, 16'd1);
    tick();
    chk_issue("add", 16'h0000, 16'h0000, 4'b0010, 4'd1);

    // Writeback r2, r3 then AND r4,r2,r3
    bus.InstrValid = 1'b0;
    bus.WbEnable = 1'b1; bus.WbReg = 4'd2; bus.WbData = 16'h1234;
    tick();
    chk("wb_novld", {15'd0, bus.IssueValid}, 16'd0);
    bus.WbReg = 4'd3; bus.WbData = 16'h00FF;
    tick();
    bus.WbEnable = 1'b0;
    bus.InstrValid = 1'b1; bus.Instr = 16'h0423;
    tick();
    chk_issue("and", 16'h1234, 16'h00FF, 4'b0000, 4'd4);

    // SUB r5,r2,r3 then dependent OR r6,r5,r2
    bus.Instr = 16'h3523;
    tick();
    chk_issue("sub", 16'h1234, 16'h00FF, 4'b0110, 4'd5);
    bus.Instr = 16'h1652;
    #1;
    chk("raw_stall", {15'd0, bus.InstrReady}, 16'd0);
    tick();
    chk("raw_novld", {15'd0, bus.IssueValid}, 16'd0);
    bus.WbEnable = 1'b1; bus.WbReg = 4'd5; bus.WbData = 16'h1135;
    #1;
    chk("raw_release", {15'd0, bus.InstrReady}, 16'd1);
    tick();
    chk_issue("or_byp", 16'h1135, 16'h1234, 4'b0001, 4'd6);

    // Write to r0 with a same-cycle read of r0, then a later read
    bus.WbReg = 4'd0; bus.WbData = 16'hFFFF;
    bus.Instr = 16'h2800;
    tick();
    chk_issue("r0_same", 16'h0000, 16'h0000, 4'b0010, 4'd8);
    bus.WbEnable = 1'b0;
    bus.Instr = 16'h2900;
    tick();
    chk_issue("r0_later", 16'h0000, 16'h0000, 4'b0010, 4'd9);

    // Illegal opcode with pending operands is still accepted
    bus.Instr = 16'h9666;
    #1;
    chk("ill_ready", {15'd0, bus.InstrReady}, 16'd1);
    tick();
    chk("ill_pulse", {15'd0, bus.IllegalOp},  16'd1);
    chk("ill_novld", {15'd0, bus.IssueValid}, 16'd0);
    chk("ill_ctl",   {12'd0, bus.Control}, 16'h0002);
    chk("ill_dst",   {12'd0, bus.DestReg}, 16'h0009);
    bus.InstrValid = 1'b0;
    tick();
    chk("ill_once", {15'd0, bus.IllegalOp}, 16'd0);

    // Decode sweep, back to back, independent destinations
    bus.InstrValid = 1'b1;
    bus.Instr = 16'h0A23; tick(); chk_issue("sw0", 16'h1234, 16'h00FF, 4'b0000, 4'd10);
    bus.Instr = 16'h1B23; tick(); chk_issue("sw1", 16'h1234, 16'h00FF, 4'b0001, 4'd11);
    bus.Instr = 16'h2C23; tick(); chk_issue("sw2", 16'h1234, 16'h00FF, 4'b0010, 4'd12);
    bus.Instr = 16'h3D23; tick(); chk_issue("sw3", 16'h1234, 16'h00FF, 4'b0110, 4'd13);
    bus.Instr = 16'h4E23; tick(); chk_issue("sw4", 16'h1234, 16'h00FF, 4'b0111, 4'd14);
    bus.Instr = 16'h5F23; tick(); chk_issue("sw5", 16'h1234, 16'h00FF, 4'b1100, 4'd15);

    // WAW: r10 still pending
    bus.Instr = 16'h2A00;
    #1;
    chk("waw_stall", {15'd0, bus.InstrReady}, 16'd0);

    // Reset mid-stall: ADD r7,r2,r3 then AND r5,r7,r0 waits
    bus.Instr = 16'h2723;
    tick();
    chk_issue("add_r7", 16'h1234, 16'h00FF, 4'b0010, 4'd7);
    bus.Instr = 16'h0570;
    #1;
    chk("dep_stall", {15'd0, bus.InstrReady}, 16'd0);
    tick();
    chk("dep_novld", {15'd0, bus.IssueValid}, 16'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rd1", bus.ReadData1, 16'h0000);
    chk("async_ctl", {12'd0, bus.Control}, 16'd0);
    chk("async_rdy", {15'd0, bus.InstrReady}, 16'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {15'd0, bus.InstrReady}, 16'd1);
    tick();
    chk_issue("post_rst", 16'h0000, 16'h0000, 4'b0000, 4'd5);

    bus.InstrValid = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
